// File: rtl/paddle_hit_detector.sv
// Paddle/ball collision, miss, scoring and serve sequencing for the pong datapath.
// Every output is registered: decisions on inputs sampled at edge N show up after edge N.
module paddle_hit_detector #(
  parameter int LEFT_HIT_X     = 30,
  parameter int RIGHT_HIT_X    = 210,
  parameter int LEFT_MISS_X    = 15,
  parameter int RIGHT_MISS_X   = 225,
  parameter int PADDLE_HEIGHT  = 40,
  parameter int BALL_SIZE      = 5,
  parameter int LOCKOUT_CYCLES = 8,
  parameter int SERVE_CYCLES   = 4,
  parameter int WIN_SCORE      = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       newGame,
  input  logic [7:0] ballXValue,
  input  logic [8:0] ballYValue,
  input  logic       direction,
  input  logic [8:0] leftPaddleY,
  input  logic [8:0] rightPaddleY,
  output logic       changeXDirection,
  output logic [1:0] changeYDirection,
  output logic [3:0] leftScore,
  output logic [3:0] rightScore,
  output logic       pointScored,
  output logic       ballReset,
  output logic       gameOver,
  output logic       winner
);

  localparam int BSH_I = BALL_SIZE / 2;
  localparam int PHH_I = PADDLE_HEIGHT / 2;
  localparam logic [7:0] L_HIT  = LEFT_HIT_X[7:0];
  localparam logic [7:0] R_HIT  = RIGHT_HIT_X[7:0];
  localparam logic [7:0] L_MISS = LEFT_MISS_X[7:0];
  localparam logic [7:0] R_MISS = RIGHT_MISS_X[7:0];
  localparam logic [9:0] BS     = BALL_SIZE[9:0];
  localparam logic [9:0] PH     = PADDLE_HEIGHT[9:0];
  localparam logic [9:0] BSH    = BSH_I[9:0];
  localparam logic [9:0] PHH    = PHH_I[9:0];
  localparam logic [7:0] LOCK_C = LOCKOUT_CYCLES[7:0];
  localparam logic [7:0] SERV_C = SERVE_CYCLES[7:0];
  localparam logic [3:0] WIN    = WIN_SCORE[3:0];

  typedef enum logic [1:0] {PLAY, LOCKOUT, SCORED, GAME_OVER} state_t;

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] lscore_n, rscore_n;
  logic       cx_n, pt_n;
  logic [1:0] cy_n;
  logic [9:0] by, lp, rp;
  logic       right_hit, left_hit, right_miss, left_miss;

  function automatic logic overlap(input logic [9:0] y, input logic [9:0] p);
    return (y + BS > p) && (y < p + PH);
  endfunction

  function automatic logic upper(input logic [9:0] y, input logic [9:0] p);
    return (y + BSH) < (p + PHH);
  endfunction

  // Zero-extend so the +BALL_SIZE / +PADDLE_HEIGHT sums never wrap.
  assign by = {1'b0, ballYValue};
  assign lp = {1'b0, leftPaddleY};
  assign rp = {1'b0, rightPaddleY};

  assign right_hit  = direction && ballXValue >= R_HIT && ballXValue < R_MISS && overlap(by, rp);
  assign left_hit   = !direction && ballXValue > L_MISS && ballXValue <= L_HIT && overlap(by, lp);
  assign right_miss = direction && ballXValue >= R_MISS;
  assign left_miss  = !direction && ballXValue <= L_MISS;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= PLAY;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      PLAY: begin
        if (right_hit || left_hit) begin
          state_n = LOCKOUT;
          cnt_n   = LOCK_C;
        end else if (right_miss || left_miss) begin
          state_n = SCORED;
          cnt_n   = SERV_C;
        end
      end
      LOCKOUT: begin
        cnt_n = cnt - 8'd1;
        if (cnt <= 8'd1) begin
          state_n = PLAY;
          cnt_n   = '0;
        end
      end
      SCORED: begin
        cnt_n = cnt - 8'd1;
        if (cnt <= 8'd1) begin
          state_n = (leftScore == WIN || rightScore == WIN) ? GAME_OVER : PLAY;
          cnt_n   = '0;
        end
      end
      default: ;
    endcase
    if (newGame) begin
      state_n = SCORED;
      cnt_n   = SERV_C;
    end
  end

  always_comb begin
    cx_n     = 1'b0;
    cy_n     = 2'b00;
    pt_n     = 1'b0;
    lscore_n = leftScore;
    rscore_n = rightScore;
    if (newGame) begin
      lscore_n = '0;
      rscore_n = '0;
    end else if (state == PLAY) begin
      if (right_hit) begin
        cx_n = 1'b1;
        cy_n = upper(by, rp) ? 2'b10 : 2'b01;
      end else if (left_hit) begin
        cx_n = 1'b1;
        cy_n = upper(by, lp) ? 2'b10 : 2'b01;
      end else if (right_miss) begin
        pt_n     = 1'b1;
        lscore_n = (leftScore < WIN) ? leftScore + 4'd1 : leftScore;
      end else if (left_miss) begin
        pt_n     = 1'b1;
        rscore_n = (rightScore < WIN) ? rightScore + 4'd1 : rightScore;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      changeXDirection <= 1'b0;
      changeYDirection <= 2'b00;
      pointScored      <= 1'b0;
      leftScore        <= '0;
      rightScore       <= '0;
      ballReset        <= 1'b0;
      gameOver         <= 1'b0;
      winner           <= 1'b0;
    end else begin
      changeXDirection <= cx_n;
      changeYDirection <= cy_n;
      pointScored      <= pt_n;
      leftScore        <= lscore_n;
      rightScore       <= rscore_n;
      ballReset        <= (state_n == SCORED);
      gameOver         <= (state_n == GAME_OVER);
      winner           <= (state_n == GAME_OVER) && (rscore_n == WIN);
    end
  end

endmodule

// File: tb/tb_paddle_hit_detector.sv
// Directed + randomized bench; the reference tracks blocked/serve windows as absolute edge indices.
module tb_paddle_hit_detector;
  localparam int LHX = 30, RHX = 210, LMX = 15, RMX = 225;
  localparam int PH = 40, BSZ = 5, LOCK = 8, SERVE = 4, WIN = 9;

  logic       clock = 1'b0, reset = 1'b0, newGame = 1'b0, direction = 1'b0;
  logic [7:0] ballXValue = '0;
  logic [8:0] ballYValue = '0, leftPaddleY = '0, rightPaddleY = '0;
  logic       changeXDirection, pointScored, ballReset, gameOver, winner;
  logic [1:0] changeYDirection;
  logic [3:0] leftScore, rightScore;

  paddle_hit_detector dut (
    .clock(clock), .reset(reset), .newGame(newGame), .ballXValue(ballXValue),
    .ballYValue(ballYValue), .direction(direction), .leftPaddleY(leftPaddleY),
    .rightPaddleY(rightPaddleY), .changeXDirection(changeXDirection),
    .changeYDirection(changeYDirection), .leftScore(leftScore), .rightScore(rightScore),
    .pointScored(pointScored), .ballReset(ballReset), .gameOver(gameOver), .winner(winner)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0;
  int cyc = 0, last_e = 0, resume = 0, serve_end = 0, over_at = 0;
  bit over_v = 0;
  int ls = 0, rs = 0, e_cx = 0, e_cy = 0, e_pt = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit ovl(input int y, input int p);
    return (y + BSZ > p) && (y < p + PH);
  endfunction

  function automatic int half(input int y, input int p);
    return (y + BSZ / 2 < p + PH / 2) ? 2 : 1;
  endfunction

  task automatic model_reset();
    resume = 0; serve_end = 0; over_v = 0; ls = 0; rs = 0;
    e_cx = 0; e_cy = 0; e_pt = 0; last_e = cyc;
  endtask

  task automatic point(input int e);
    e_pt = 1;
    serve_end = e + SERVE;
    resume = e + SERVE + 1;
    if (ls == WIN || rs == WIN) begin
      over_v = 1;
      over_at = e + SERVE;
    end
  endtask

  // Reference for the edge just taken, using inputs that were applied before it.
  task automatic model(input int e);
    int x, y, lpy, rpy;
    x = ballXValue; y = ballYValue; lpy = leftPaddleY; rpy = rightPaddleY;
    e_cx = 0; e_cy = 0; e_pt = 0; last_e = e;
    if (newGame) begin
      ls = 0; rs = 0; over_v = 0;
      serve_end = e + SERVE;
      resume = e + SERVE + 1;
    end else if (e >= resume && !over_v) begin
      if (direction && x >= RHX && x < RMX && ovl(y, rpy)) begin
        e_cx = 1; e_cy = half(y, rpy); resume = e + 1 + LOCK;
      end else if (!direction && x > LMX && x <= LHX && ovl(y, lpy)) begin
        e_cx = 1; e_cy = half(y, lpy); resume = e + 1 + LOCK;
      end else if (direction && x >= RMX) begin
        if (ls < WIN) ls++;
        point(e);
      end else if (!direction && x <= LMX) begin
        if (rs < WIN) rs++;
        point(e);
      end
    end
  endtask

  task automatic check_all(input string tag);
    bit go;
    go = over_v && (last_e >= over_at);
    chk({tag, ".cx"}, 16'(changeXDirection), 16'(e_cx));
    chk({tag, ".cy"}, 16'(changeYDirection), 16'(e_cy));
    chk({tag, ".pt"}, 16'(pointScored), 16'(e_pt));
    chk({tag, ".ls"}, 16'(leftScore), 16'(ls));
    chk({tag, ".rs"}, 16'(rightScore), 16'(rs));
    chk({tag, ".br"}, 16'(ballReset), 16'(last_e < serve_end));
    chk({tag, ".go"}, 16'(gameOver), 16'(go));
    chk({tag, ".win"}, 16'(winner), 16'(go && rs == WIN));
  endtask

  task automatic step(input string tag);
    @(posedge clock);
    model(cyc);
    cyc++;
    #1 check_all(tag);
  endtask

  task automatic set_in(input bit d, input int x, input int y, input int lpy, input int rpy);
    direction = d; ballXValue = 8'(x); ballYValue = 9'(y);
    leftPaddleY = 9'(lpy); rightPaddleY = 9'(rpy);
  endtask

  initial begin
    #2;
    chk("rst.cx", 16'(changeXDirection), 16'd0);
    chk("rst.cy", 16'(changeYDirection), 16'd0);
    chk("rst.ls", 16'(leftScore), 16'd0);
    chk("rst.rs", 16'(rightScore), 16'd0);
    chk("rst.br", 16'(ballReset), 16'd0);
    chk("rst.go", 16'(gameOver), 16'd0);
    #10 reset = 1'b1;
    model_reset();

    // right hit, upper half, ball parked in window through lockout
    set_in(1, 210, 205, 0, 200);
    for (int i = 0; i < 11; i++) step("rhit");
    // left hit, lower half
    set_in(0, 30, 235, 200, 0);
    for (int i = 0; i < 10; i++) step("lhit");
    // right miss sweep with ball below paddle
    for (int x = 209; x <= 225; x++) begin
      set_in(1, x, 240, 0, 100);
      step("rmiss");
    end
    set_in(1, 120, 240, 0, 100);
    for (int i = 0; i < 6; i++) step("serve");

    // fresh game then nine left misses to game over
    newGame = 1'b1; step("ng0"); newGame = 1'b0;
    set_in(0, 10, 100, 300, 300);
    for (int i = 0; i < 9 * (SERVE + 1) + 12; i++) step("gover");
    newGame = 1'b1; step("ng1"); newGame = 1'b0;
    set_in(0, 120, 100, 300, 300);
    for (int i = 0; i < 6; i++) step("ngserve");

    // async reset during lockout
    set_in(1, 215, 205, 0, 200);
    for (int i = 0; i < 4; i++) step("prelock");
    #2 reset = 1'b0;
    #1;
    chk("arst.cx", 16'(changeXDirection), 16'd0);
    chk("arst.cy", 16'(changeYDirection), 16'd0);
    chk("arst.ls", 16'(leftScore), 16'd0);
    chk("arst.br", 16'(ballReset), 16'd0);
    model_reset();
    #1 reset = 1'b1;
    step("posthit");
    for (int i = 0; i < 4; i++) step("postlock");

    // randomized play
    for (int i = 0; i < 800; i++) begin
      int x, y, lpy, rpy, sel;
      bit d;
      d = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 3);
      x = (sel == 0) ? $urandom_range(205, 235) : (sel == 1) ? $urandom_range(5, 35) :
          (sel == 2) ? $urandom_range(0, 255) : (d ? $urandom_range(205, 235) : $urandom_range(5, 35));
      lpy = $urandom_range(0, 470);
      rpy = $urandom_range(0, 470);
      y = (d ? rpy : lpy) + $urandom_range(0, 60) - 10;
      if (y < 0) y = 0;
      if (y > 511) y = 511;
      set_in(d, x, y, lpy, rpy);
      newGame = ($urandom_range(0, 79) == 0);
      step("rand");
      newGame = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
